// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the SIMPLE pipeline sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STALL = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_HALT  = 3'd5
    } state_e;

    localparam logic [1:0] OP1_ALU = 2'b11;
    localparam logic [3:0] OP3_HLT = 4'b1111;
    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [4:0] BR_B    = 5'b10100;
    localparam logic [4:0] BR_COND = 5'b10111;

    localparam int unsigned DRAIN_CYCLES = 3;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an asynchronous button level, plus rising-edge detect.
module btn_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], btn_i};
        end
    end

    // sync_q[1] is the first metastability-safe sample; sync_q[2] is its previous value
    assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Run/stop, RAW-hazard stall, branch flush and halt sequencing for the 5-stage pipeline.
// Optional single-step from IDLE via the PIPE_SINGLE_STEP_EN macro (adds the step input).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NREG_BITS   = 3,
    parameter int unsigned FLUSH_DEPTH = 2,
    parameter int unsigned HAZ_DEPTH   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 exec,
`ifdef PIPE_SINGLE_STEP_EN
    input  logic                 step,
`endif
    input  logic                 id_rs_en,
    input  logic [NREG_BITS-1:0] id_rs,
    input  logic                 id_rt_en,
    input  logic [NREG_BITS-1:0] id_rt,
    input  logic                 id_halt,
    input  logic                 ex_wr_en,
    input  logic [NREG_BITS-1:0] ex_wr_addr,
    input  logic                 mem_wr_en,
    input  logic [NREG_BITS-1:0] mem_wr_addr,
    input  logic                 br_taken,
    output logic                 pc_en,
    output logic                 ifid_en,
    output logic                 idex_bubble,
    output logic                 flush,
    output logic                 running,
    output logic                 halted
);

    localparam int unsigned FCNT_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [FCNT_W-1:0] FLUSH_LOAD = FCNT_W'(FLUSH_DEPTH - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);
    localparam logic CHK_MEM = 1'(HAZ_DEPTH >= 2);

    state_e             state_q, state_d;
    logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
    logic [2:0]         dcnt_q, dcnt_d;
    logic               fpulse_q, fpulse_d;
    logic               exec_rise;
    logic               hz_ex, hz_mem, hz;

    btn_sync_edge u_exec_sync (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (exec),
        .rise_o (exec_rise)
    );

`ifdef PIPE_SINGLE_STEP_EN
    logic step_rise;
    logic step_q, step_d;

    btn_sync_edge u_step_sync (
        .clock  (clock),
        .reset  (reset),
        .btn_i  (step),
        .rise_o (step_rise)
    );
`endif

    // P5 writes on the falling edge, so only P3 and P4 producers can collide with the P2 read
    assign hz_ex  = (id_rs_en & ex_wr_en & (id_rs == ex_wr_addr))
                  | (id_rt_en & ex_wr_en & (id_rt == ex_wr_addr));
    assign hz_mem = CHK_MEM & ((id_rs_en & mem_wr_en & (id_rs == mem_wr_addr))
                             | (id_rt_en & mem_wr_en & (id_rt == mem_wr_addr)));
    assign hz     = hz_ex | hz_mem;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            fcnt_q   <= '0;
            dcnt_q   <= '0;
            fpulse_q <= 1'b0;
`ifdef PIPE_SINGLE_STEP_EN
            step_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            fcnt_q   <= fcnt_d;
            dcnt_q   <= dcnt_d;
            fpulse_q <= fpulse_d;
`ifdef PIPE_SINGLE_STEP_EN
            step_q   <= step_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        dcnt_d      = dcnt_q;
        fpulse_d    = 1'b0;
`ifdef PIPE_SINGLE_STEP_EN
        step_d      = step_q;
`endif
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        flush       = 1'b0;
        running     = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                flush = fpulse_q;
                if (exec_rise) begin
                    state_d = ST_RUN;
`ifdef PIPE_SINGLE_STEP_EN
                end else if (step_rise) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    dcnt_d  = '0;
                    step_d  = 1'b1;
                    state_d = ST_DRAIN;
`endif
                end
            end

            // RUN and STALL share one decision: a stall simply re-checks the hazard each cycle
            ST_RUN, ST_STALL: begin
                running = 1'b1;
                if (br_taken) begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                    flush   = 1'b1;
                    fcnt_d  = FLUSH_LOAD;
                    state_d = ST_FLUSH;
                end else if (exec_rise || id_halt) begin
                    dcnt_d  = '0;
                    state_d = ST_DRAIN;
                end else if (hz) begin
                    state_d = ST_STALL;
                end else begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_bubble = 1'b0;
                    state_d     = ST_RUN;
                end
            end

            ST_FLUSH: begin
                running = 1'b1;
                pc_en   = 1'b1;
                ifid_en = 1'b1;
                flush   = 1'b1;
                if (exec_rise) begin
                    dcnt_d  = '0;
                    state_d = ST_DRAIN;
                end else if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - FCNT_W'(1);
                end
            end

            ST_DRAIN: begin
                running = 1'b1;
                if (dcnt_q == DRAIN_LAST) begin
`ifdef PIPE_SINGLE_STEP_EN
                    state_d = step_q ? ST_IDLE : ST_HALT;
                    step_d  = 1'b0;
`else
                    state_d = ST_HALT;
`endif
                end else begin
                    dcnt_d = dcnt_q + 3'd1;
                end
            end

            ST_HALT: begin
                halted = 1'b1;
                if (exec_rise) begin
                    fpulse_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (reset) begin
            flush = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: mode-based reference model compared every cycle, plus directed literal checks.
module tb_pipe_hazard_ctrl;

    localparam int unsigned NB = 3;
    localparam int FD = 2;
    localparam int DRAIN_N = 3;

    // output vector order: {pc_en, ifid_en, idex_bubble, flush, running, halted}
    localparam logic [5:0] RESETV = 6'b001100;
    localparam logic [5:0] IDLEV  = 6'b001000;
    localparam logic [5:0] PULSEV = 6'b001100;
    localparam logic [5:0] RUNV   = 6'b110010;
    localparam logic [5:0] HOLDV  = 6'b001010;
    localparam logic [5:0] FLUSHV = 6'b111110;
    localparam logic [5:0] HALTV  = 6'b001001;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic exec = 1'b0;
    logic id_rs_en = 1'b0, id_rt_en = 1'b0, id_halt = 1'b0;
    logic [NB-1:0] id_rs = '0, id_rt = '0, ex_wr_addr = '0, mem_wr_addr = '0;
    logic ex_wr_en = 1'b0, mem_wr_en = 1'b0, br_taken = 1'b0;
    logic pc_en, ifid_en, idex_bubble, flush, running, halted;
    logic [5:0] outs;

    int total = 0;
    int passed = 0;
    int stall_run = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.NREG_BITS(NB), .FLUSH_DEPTH(FD), .HAZ_DEPTH(2)) dut (
        .clock(clock), .reset(reset), .exec(exec),
        .id_rs_en(id_rs_en), .id_rs(id_rs), .id_rt_en(id_rt_en), .id_rt(id_rt),
        .id_halt(id_halt), .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .br_taken(br_taken),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_bubble(idex_bubble),
        .flush(flush), .running(running), .halted(halted)
    );

    assign outs = {pc_en, ifid_en, idex_bubble, flush, running, halted};

    // Reference model: core on/halted flags, remaining flush/drain cycle counts, exec sample history
    bit       m_on = 1'b0, m_halt = 1'b0, m_pulse = 1'b0;
    int       m_flush_left = 0, m_drain_left = 0;
    bit [2:0] m_h = 3'b000;
    bit       m_rise;
    assign m_rise = m_h[1] && !m_h[2];

    function automatic bit model_hz();
        bit r;
        r = (id_rs_en && ex_wr_en && id_rs == ex_wr_addr) || (id_rt_en && ex_wr_en && id_rt == ex_wr_addr)
         || (id_rs_en && mem_wr_en && id_rs == mem_wr_addr) || (id_rt_en && mem_wr_en && id_rt == mem_wr_addr);
        return r;
    endfunction

    function automatic logic [5:0] model_outs();
        if (reset)                  return RESETV;
        if (m_halt)                 return HALTV;
        if (!m_on)                  return m_pulse ? PULSEV : IDLEV;
        if (m_drain_left > 0)       return HOLDV;
        if (m_flush_left > 0)       return FLUSHV;
        if (br_taken)               return FLUSHV;
        if (m_rise || id_halt || model_hz()) return HOLDV;
        return RUNV;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_on = 1'b0; m_halt = 1'b0; m_pulse = 1'b0;
            m_flush_left = 0; m_drain_left = 0; m_h = 3'b000;
        end else begin
            m_pulse = 1'b0;
            if (m_halt) begin
                if (m_rise) begin m_halt = 1'b0; m_pulse = 1'b1; end
            end else if (!m_on) begin
                if (m_rise) m_on = 1'b1;
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) begin m_on = 1'b0; m_halt = 1'b1; end
            end else if (m_flush_left > 0) begin
                if (m_rise) begin m_flush_left = 0; m_drain_left = DRAIN_N; end
                else m_flush_left--;
            end else if (br_taken) begin
                m_flush_left = FD;
            end else if (m_rise || id_halt) begin
                m_drain_left = DRAIN_N;
            end
            m_h = {m_h[1:0], exec};
        end
    end

    task automatic chk(input string name, input logic [5:0] got, input logic [5:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    // Every-cycle comparison against the model, plus the consecutive-stall bound
    always @(negedge clock) begin
        chk("model", outs, model_outs());
        if (!reset && m_on && !m_halt && m_drain_left == 0 && m_flush_left == 0
            && !br_taken && !m_rise && !id_halt && model_hz()) begin
            stall_run++;
            total++;
            if (stall_run <= 2) passed++;
            else $display("FAIL stall_bound: got %0d consecutive stalls, allowed 2", stall_run);
        end else begin
            stall_run = 0;
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic look(input string name, input logic [5:0] exp);
        @(negedge clock);
        chk(name, outs, exp);
    endtask

    // exec held for two edges; w = outputs while syncing, d = detect cycle, a = cycle after
    task automatic press(input string name, input logic [5:0] w, input logic [5:0] d, input logic [5:0] a);
        exec = 1'b1;
        look({name, "_w1"}, w); nxt();
        look({name, "_w2"}, w); nxt();
        exec = 1'b0;
        look({name, "_det"}, d); nxt();
        look({name, "_after"}, a); nxt();
    endtask

    initial begin
        look("reset", RESETV);
        nxt();
        reset = 1'b0;
        look("idle", IDLEV); nxt();
        nxt();

        press("start", IDLEV, IDLEV, RUNV);
        look("run", RUNV); nxt();

        // producer in P3 then P4 on rs: two bubbles
        ex_wr_en = 1'b1; ex_wr_addr = 3'd3; id_rs_en = 1'b1; id_rs = 3'd3;
        look("hz_p3", HOLDV); nxt();
        ex_wr_en = 1'b0; mem_wr_en = 1'b1; mem_wr_addr = 3'd3;
        look("hz_p4", HOLDV); nxt();
        mem_wr_en = 1'b0;
        look("hz_clear", RUNV); nxt();
        id_rs_en = 1'b0;

        // rt-only hazard against P4, then same addresses with rt disabled
        id_rs = 3'd5; id_rt = 3'd5; id_rt_en = 1'b1; mem_wr_en = 1'b1; mem_wr_addr = 3'd5;
        look("hz_rt", HOLDV); nxt();
        mem_wr_en = 1'b0;
        look("hz_rt_clear", RUNV); nxt();
        mem_wr_en = 1'b1; id_rt_en = 1'b0;
        look("rt_disabled", RUNV); nxt();
        mem_wr_en = 1'b0;

        // taken branch beats an active hazard
        ex_wr_en = 1'b1; ex_wr_addr = 3'd2; id_rs_en = 1'b1; id_rs = 3'd2; br_taken = 1'b1;
        look("br_cycle", FLUSHV); nxt();
        br_taken = 1'b0;
        look("flush1", FLUSHV); nxt();
        look("flush2", FLUSHV); nxt();
        ex_wr_en = 1'b0; id_rs_en = 1'b0;
        look("flush_done", RUNV); nxt();

        // reset in the first FLUSH cycle
        br_taken = 1'b1;
        look("br2", FLUSHV); nxt();
        br_taken = 1'b0;
        reset = 1'b1;
        look("reset_mid_flush", RESETV); nxt();
        reset = 1'b0;
        look("idle_after_rst", IDLEV); nxt();

        press("start2", IDLEV, IDLEV, RUNV);

        // HLT in P2: bubbled at once, three drain cycles, then halted
        id_halt = 1'b1;
        look("hlt", HOLDV); nxt();
        id_halt = 1'b0;
        for (int i = 0; i < DRAIN_N; i++) begin
            look("drain", HOLDV); nxt();
        end
        look("halted", HALTV); nxt();
        press("unhalt", HALTV, HALTV, PULSEV);
        look("idle_again", IDLEV); nxt();

        // run, then user stop
        press("start3", IDLEV, IDLEV, RUNV);
        nxt();
        press("stop", RUNV, HOLDV, HOLDV);
        look("stop_drain2", HOLDV); nxt();
        look("stop_drain3", HOLDV); nxt();
        look("stop_halt", HALTV); nxt();
        nxt();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Sequencer for the 5-stage SIMPLE pipeline (P1 fetch, P2 decode/regread, P3 ALU/branch, P4 mem/IO, P5 writeback).
- Owns run/stop control from the `exec` button.
- Detects RAW hazards between the P2 reader and the P3/P4 writers. The register file writes P5 results on the falling edge, so P5 is never a hazard.
- Detects taken branches and HLT.
- Drives PC enable, P1→P2 hold, P2→P3 bubble and P1/P2 flush. Replaces the processor's constant `stall` register.

Parameters:
- NREG_BITS, 3, register address width
- FLUSH_DEPTH, 2, bubbles inserted after a taken branch (instructions in P1 and P2)
- HAZ_DEPTH, 2, deepest producer stage checked (P3 = 1, P4 = 2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- exec  in  1  run/stop request; level, synchronised and edge-detected internally
- id_rs_en  in  1  P2 instruction reads the rs field
- id_rs  in  NREG_BITS  P2 rs address
- id_rt_en  in  1  P2 instruction reads the rt field
- id_rt  in  NREG_BITS  P2 rt address
- id_halt  in  1  P2 holds HLT (op1 = 11, op3 = 1111)
- ex_wr_en  in  1  P3 instruction writes the register file
- ex_wr_addr  in  NREG_BITS  P3 destination
- mem_wr_en  in  1  P4 instruction writes the register file
- mem_wr_addr  in  NREG_BITS  P4 destination
- br_taken  in  1  P3 branch condition resolved taken (single cycle)
- pc_en  out  1  P1 PC update enable
- ifid_en  out  1  P1→P2 register load enable
- idex_bubble  out  1  force NOP (RegWrite = 0, MemWrite = 0) into P3
- flush  out  1  kill P1 and P2 contents
- running  out  1  core is executing
- halted  out  1  HLT retired / pipeline drained

Behaviour:
- State register values: IDLE, RUN, STALL, FLUSH, DRAIN, HALT.
- Reset: IDLE. Outputs: pc_en = 0, ifid_en = 0, idex_bubble = 1, flush = 1, running = 0, halted = 0. The flush counter and exec synchroniser are cleared.
- exec_rise: rising edge of `exec` after a 2-flop synchroniser. Latency from `exec` to the state change is 3 cycles.
- IDLE:
  - exec_rise → RUN.
  - Outputs match reset, except flush = 0 once in IDLE.
- RUN:
  - pc_en = ifid_en = 1, idex_bubble = 0, flush = 0, running = 1.
- Hazard definition: hz = (id_rs_en & ex_wr_en & id_rs == ex_wr_addr) | the same for id_rt | the same pair of checks against mem_wr_* when HAZ_DEPTH = 2.
- Event priority, same cycle: br_taken > exec_rise (stop) > id_halt > hz.
  - br_taken → FLUSH, with flush = 1 and idex_bubble = 1 in that cycle. A hazard on the wrong-path instruction is ignored.
  - exec_rise in RUN/STALL/FLUSH → DRAIN (user stop).
  - id_halt → DRAIN. HLT itself is bubbled; pc_en = 0 from that cycle.
  - hz → STALL, with pc_en = ifid_en = 0 and idex_bubble = 1 combinationally in the detecting cycle.
- STALL:
  - Same outputs as the stalled cycle. Re-evaluate hz every cycle; !hz → RUN.
  - Maximum 2 consecutive stall cycles (producer in P3); exceeding this is a bench assertion.
  - br_taken cannot occur while stalled, since P3 holds a bubble.
- FLUSH:
  - Counter loaded with FLUSH_DEPTH-1. flush = idex_bubble = 1 and pc_en = 1 so the target fetches.
  - Counter = 0 → RUN.
  - The counter must not wrap. With FLUSH_DEPTH = 1, FLUSH lasts exactly 1 cycle.
- DRAIN:
  - pc_en = ifid_en = 0, idex_bubble = 1, running = 1.
  - A 3-bit counter waits 3 cycles for P3–P5 to retire, then → HALT.
  - br_taken during DRAIN is ignored.
- HALT:
  - halted = 1, running = 0, all enables 0.
  - exec_rise → IDLE, pulsing flush for 1 cycle. The PC is reset by the core's own reset, not by this block.
- Reset mid-operation: immediate return to IDLE with reset outputs. No partial flush count is retained.

Optional Feature:
- Macro `PIPE_SINGLE_STEP_EN`.
- With it defined:
  - A second `exec` press in IDLE within 4 cycles is not used. Instead, an added input `step` (1 bit, synchronised and edge-detected the same way as `exec`) in IDLE issues exactly one fetch.
  - Behaviour: pc_en = 1 for one cycle, then DRAIN, then back to IDLE (not HALT).
- Without it: no `step` port; behaviour as above.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum;
  - opcode constants: OP1_ALU = 2'b11, OP3_HLT = 4'b1111, OP1_LD = 2'b00, OP1_ST = 2'b01, BR_B = 5'b10100, BR_COND = 5'b10111;
  - DRAIN_CYCLES = 3.
- One sub-module, `btn_sync_edge`: 2-flop synchroniser plus rising-edge detector, instantiated for `exec` (and `step`).

Test Plan:
- Reset asserted mid-FLUSH (counter = 1) → next cycle: state IDLE, flush = 1, pc_en = 0, running = 0.
- RUN with ex_wr_en = 1, ex_wr_addr = 3, id_rs_en = 1, id_rs = 3 → same cycle pc_en = 0, idex_bubble = 1. Next cycle the producer moves to P4 (mem_wr_addr = 3) and the stall holds. The cycle after, hz = 0 → pc_en = 1. Exactly 2 bubbles.
- br_taken = 1 together with an active hz → flush = 1 for FLUSH_DEPTH = 2 cycles, no STALL entered, pc_en = 1 throughout.
- id_halt = 1 in RUN → pc_en = 0 immediately, running = 1 for 3 cycles, then halted = 1. exec press → IDLE, halted = 0.
- exec pulse in IDLE → running = 1 exactly 3 cycles after the `exec` rise. A second exec pulse → DRAIN → HALT.
- Hazard on the rt field only (id_rt = 5 vs mem_wr_addr = 5, rs enable 0) → 1 stall cycle. The same case with id_rt_en = 0 → no stall.
